dcache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between cpu data port and data_memory.
//  cpu side: byte-wide READMEM/WRITEMEM/BUSYWAIT port. Memory side: 32-bit block-wide port.

---
 rtl/dcache_pkg.sv | 14 +
 rtl/dcache_if.sv | 29 ++
 rtl/dcache_array.sv | 51 +++++
 rtl/dcache.sv | 98 +++++++++
 tb/tb_dcache.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// dcache shared header: geometry, address field widths and FSM state encoding.
package dcache_pkg;
   localparam int NUM_SETS    = 8;
   localparam int BLOCK_BYTES = 4;
   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 8;
   localparam int OFF_W       = 2;
   localparam int IDX_W       = 3;
   localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
   localparam int BLOCK_W     = BLOCK_BYTES * DATA_W;
   localparam int MADDR_W     = TAG_W + IDX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
endpackage

// File: rtl/dcache_if.sv
// dcache bus bundle: cpu byte port plus memory block port.
interface dcache_if;
   import dcache_pkg::*;

   logic                READMEM;
   logic                WRITEMEM;
   logic [ADDR_W-1:0]   ADDRESS;
   logic [DATA_W-1:0]   WRITEDATA;
   logic [DATA_W-1:0]   READDATA;
   logic                BUSYWAIT;
   logic                MEM_READ;
   logic                MEM_WRITE;
   logic [MADDR_W-1:0]  MEM_ADDRESS;
   logic [BLOCK_W-1:0]  MEM_WRITEDATA;
   logic [BLOCK_W-1:0]  MEM_READDATA;
   logic                MEM_BUSYWAIT;

   // cpu + memory side (drives requests and memory responses)
   modport master (
      output READMEM, WRITEMEM, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );

   // cache side
   modport slave (
      input  READMEM, WRITEMEM, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );
endinterface

// File: rtl/dcache_array.sv
// dcache storage: valid/dirty/tag/data per set, async read, sync byte write or line fill.
module dcache_array
   import dcache_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic [IDX_W-1:0]    idx,
   input  logic [OFF_W-1:0]    off,
   input  logic                byte_we,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                fill_we,
   input  logic [TAG_W-1:0]    fill_tag,
   input  logic [BLOCK_W-1:0]  fill_data,
   output logic                valid,
   output logic                dirty,
   output logic [TAG_W-1:0]    tag,
   output logic [BLOCK_W-1:0]  line
);
   logic [NUM_SETS-1:0]              valid_arr;
   logic [NUM_SETS-1:0]              dirty_arr;
   logic [NUM_SETS-1:0][TAG_W-1:0]   tag_arr;
   logic [NUM_SETS-1:0][BLOCK_W-1:0] data_arr;

   assign valid = valid_arr[idx];
   assign dirty = dirty_arr[idx];
   assign tag   = tag_arr[idx];
   assign line  = data_arr[idx];

   // status bits: cleared by reset, a fill makes the line clean, a store makes it dirty
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         valid_arr <= '0;
         dirty_arr <= '0;
      end else if (fill_we) begin
         valid_arr[idx] <= 1'b1;
         dirty_arr[idx] <= 1'b0;
      end else if (byte_we) begin
         dirty_arr[idx] <= 1'b1;
      end
   end

   // tag/data payload is never cleared; valid gates its use
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         tag_arr[idx]  <= fill_tag;
         data_arr[idx] <= fill_data;
      end else if (byte_we) begin
         data_arr[idx][off*DATA_W +: DATA_W] <= wdata;
      end
   end
endmodule

// File: rtl/dcache.sv
// dcache top: direct-mapped write-back/write-allocate cache, miss FSM and memory port.
module dcache
   import dcache_pkg::*;
(
   input  logic     CLK,
   input  logic     RESET,
   dcache_if.slave  bus
);
   logic [TAG_W-1:0]   tag;
   logic [IDX_W-1:0]   idx;
   logic [OFF_W-1:0]   off;
   state_t             state;
   logic               hit_ack;
   logic [TAG_W-1:0]   miss_tag;
   logic [IDX_W-1:0]   miss_idx;
   logic [BLOCK_W-1:0] fill_buf;
   logic [IDX_W-1:0]   arr_idx;
   logic               req, hit, byte_we, fill_we;
   logic               v_valid, v_dirty;
   logic [TAG_W-1:0]   v_tag;
   logic [BLOCK_W-1:0] v_line;

   assign {tag, idx, off} = bus.ADDRESS;
   assign req      = bus.READMEM | bus.WRITEMEM;
   // during a miss the set is pinned so a dropped request cannot redirect the fill
   assign arr_idx  = (state == IDLE) ? idx : miss_idx;
   assign hit      = v_valid && (v_tag == tag);
   assign byte_we  = (state == IDLE) && !hit_ack && bus.WRITEMEM && hit;
   assign fill_we  = (state == UPDATE);
   assign bus.BUSYWAIT = req & ~hit_ack;
   assign bus.READDATA = v_line[off*DATA_W +: DATA_W];

   dcache_array u_array (
      .CLK       (CLK),
      .RESET     (RESET),
      .idx       (arr_idx),
      .off       (off),
      .byte_we   (byte_we),
      .wdata     (bus.WRITEDATA),
      .fill_we   (fill_we),
      .fill_tag  (miss_tag),
      .fill_data (fill_buf),
      .valid     (v_valid),
      .dirty     (v_dirty),
      .tag       (v_tag),
      .line      (v_line)
   );

   // miss FSM with registered memory strobes; hit_ack is a one-cycle pulse
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state             <= IDLE;
         hit_ack           <= 1'b0;
         miss_tag          <= '0;
         miss_idx          <= '0;
         fill_buf          <= '0;
         bus.MEM_READ      <= 1'b0;
         bus.MEM_WRITE     <= 1'b0;
         bus.MEM_ADDRESS   <= '0;
         bus.MEM_WRITEDATA <= '0;
      end else begin
         hit_ack <= 1'b0;
         case (state)
            IDLE: if (req && !hit_ack) begin
               if (hit) begin
                  hit_ack <= 1'b1;
               end else begin
                  miss_tag <= tag;
                  miss_idx <= idx;
                  if (v_dirty) begin
                     state             <= WRITEBACK;
                     bus.MEM_WRITE     <= 1'b1;
                     bus.MEM_ADDRESS   <= {v_tag, idx};
                     bus.MEM_WRITEDATA <= v_line;
                  end else begin
                     state           <= FETCH;
                     bus.MEM_READ    <= 1'b1;
                     bus.MEM_ADDRESS <= {tag, idx};
                  end
               end
            end
            WRITEBACK: if (!bus.MEM_BUSYWAIT) begin
               state           <= FETCH;
               bus.MEM_WRITE   <= 1'b0;
               bus.MEM_READ    <= 1'b1;
               bus.MEM_ADDRESS <= {miss_tag, miss_idx};
            end
            FETCH: if (!bus.MEM_BUSYWAIT) begin
               state        <= UPDATE;
               bus.MEM_READ <= 1'b0;
               fill_buf     <= bus.MEM_READDATA;
            end
            UPDATE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache.sv
// dcache bench: directed scenarios then random traffic against a flat-memory reference.
module tb_dcache;
   import dcache_pkg::*;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   dcache_if bus ();
   dcache dut (.CLK(CLK), .RESET(RESET), .bus(bus));

   int checks = 0;
   int errors = 0;

   // backing memory, coherent byte view, and per-set residency model
   logic [31:0] mem [64];
   logic [7:0]  ref_mem [256];
   logic        m_valid [8];
   logic        m_dirty [8];
   logic [2:0]  m_tag [8];

   int          mcnt;
   logic [37:0] wb_q [$];
   logic [5:0]  rd_q [$];
   wire         strobe = bus.MEM_READ | bus.MEM_WRITE;

   // memory: busy for 5 cycles, completes on the following edge
   assign bus.MEM_BUSYWAIT = strobe && (mcnt != 5);
   assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

   always @(posedge CLK or posedge RESET) begin
      if (RESET) mcnt <= 0;
      else if (strobe) begin
         if (mcnt == 5) begin
            mcnt <= 0;
            if (bus.MEM_WRITE) begin
               mem[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
               wb_q.push_back({bus.MEM_ADDRESS, bus.MEM_WRITEDATA});
            end else rd_q.push_back(bus.MEM_ADDRESS);
         end else mcnt <= mcnt + 1;
      end else mcnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) if (!RESET && strobe)
      chk("strobe_excl", {31'b0, bus.MEM_READ & bus.MEM_WRITE}, 32'd0);

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
         m_tag[s]   = 3'd0;
      end
      // dirty data held only in the cache is lost on reset
      for (int b = 0; b < 64; b++)
         for (int k = 0; k < 4; k++) ref_mem[b*4+k] = mem[b][8*k +: 8];
   endtask

   task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd);
      logic [2:0]  ix, tg;
      bit          hit, dv;
      int          lat, n;
      logic [31:0] blk;
      ix  = a[4:2];
      tg  = a[7:5];
      hit = m_valid[ix] && (m_tag[ix] == tg);
      dv  = !hit && m_dirty[ix];
      // miss: 1 decision edge + 6 edges per memory transfer + update + hit edge
      lat = hit ? 1 : (dv ? 15 : 9);
      for (int k = 0; k < 4; k++) blk[8*k +: 8] = ref_mem[{m_tag[ix], ix, k[1:0]}];
      wb_q.delete();
      rd_q.delete();
      @(posedge CLK); #1;
      bus.ADDRESS   = a;
      bus.WRITEDATA = wd;
      bus.READMEM   = !wr;
      bus.WRITEMEM  = wr;
      #1 chk("busy_on_req", {31'b0, bus.BUSYWAIT}, 32'd1);
      n = 0;
      while (bus.BUSYWAIT && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("latency", n, lat);
      if (!wr) chk("rdata", {24'b0, bus.READDATA}, {24'b0, ref_mem[a]});
      chk("wb_cnt", wb_q.size(), {31'b0, dv});
      if (dv && wb_q.size() == 1) begin
         chk("wb_addr", {26'b0, wb_q[0][37:32]}, {26'b0, m_tag[ix], ix});
         chk("wb_data", wb_q[0][31:0], blk);
      end
      chk("rd_cnt", rd_q.size(), {31'b0, !hit});
      if (!hit && rd_q.size() == 1) chk("rd_addr", {26'b0, rd_q[0]}, {26'b0, tg, ix});
      bus.READMEM  = 1'b0;
      bus.WRITEMEM = 1'b0;
      if (!hit) begin
         m_valid[ix] = 1'b1;
         m_tag[ix]   = tg;
         m_dirty[ix] = 1'b0;
      end
      if (wr) begin
         m_dirty[ix] = 1'b1;
         ref_mem[a]  = wd;
      end
   endtask

   initial begin
      int n;
      logic [7:0] ra;
      bit rw;
      bus.READMEM   = 1'b0;
      bus.WRITEMEM  = 1'b0;
      bus.ADDRESS   = '0;
      bus.WRITEDATA = '0;
      for (int b = 0; b < 64; b++) mem[b] = $urandom;
      model_reset();

      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", {31'b0, bus.BUSYWAIT}, 32'd0);
      chk("rst_mread", {31'b0, bus.MEM_READ}, 32'd0);
      chk("rst_mwrite", {31'b0, bus.MEM_WRITE}, 32'd0);
      RESET = 1'b0;

      access(0, 8'h24, 8'h00);   // cold miss, fetch block 0x09
      access(0, 8'h25, 8'h00);   // hit
      access(1, 8'h26, 8'hAB);   // write hit, line dirty
      access(0, 8'h26, 8'h00);   // read back 0xAB
      access(0, 8'hA4, 8'h00);   // conflict: writeback 0x09 then fetch 0x29
      access(1, 8'h10, 8'h5C);   // clean write miss, allocate
      access(0, 8'h10, 8'h00);

      // reset in the middle of a miss on 0x30 (set 4 dirty, so writeback then fetch)
      @(posedge CLK); #1;
      bus.ADDRESS = 8'h30;
      bus.READMEM = 1'b1;
      n = 0;
      while (!bus.MEM_READ && n < 40) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("fetch_seen", {31'b0, bus.MEM_READ}, 32'd1);
      #2 RESET = 1'b1;
      #1 chk("rst_mid_mread", {31'b0, bus.MEM_READ}, 32'd0);
      chk("rst_mid_mwrite", {31'b0, bus.MEM_WRITE}, 32'd0);
      bus.READMEM = 1'b0;
      @(posedge CLK); #1;
      RESET = 1'b0;
      model_reset();
      access(0, 8'h24, 8'h00);   // valid cleared: misses again

      // random traffic over a few tags to force conflicts and writebacks
      repeat (80) begin
         ra = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom)};
         rw = 1'($urandom_range(0, 1));
         access(rw, ra, 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
